// File: rtl/wbm_pkg.sv
// Shared types for the Wishbone classic initiator: FSM state encoding,
// default bus widths and the command record used by command sources.
package wbm_pkg;

  localparam int WBM_ADDR_W = 8;
  localparam int WBM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_RESP   = 2'd2,
    ST_GAP    = 2'd3
  } wbm_state_e;

  typedef struct packed {
    logic                    we;
    logic [WBM_ADDR_W-1:0]   addr;
    logic [WBM_DATA_W-1:0]   wdata;
    logic [WBM_DATA_W/8-1:0] sel;
  } wbm_cmd_t;

endpackage

// File: rtl/wbm_timeout_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
// Priority: clr, then load, then en. tc is high while count equals limit.
module wbm_timeout_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  // Counter register: clear beats load beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/wb_master_seq.sv
// Single-outstanding Wishbone classic initiator. Accepts one command on a
// valid/ready stream, runs one bus transaction with a timeout guard and
// returns read data or an error on a valid/ready response stream.
// Optional macro WBM_RETRY_EN: the first timeout of a command re-strobes it
// once after a one-cycle gap; only the second timeout reports an error.
//
// Handshake rule (both streams): a transfer happens on the rising edge of clk
// where valid and ready are both 1; valid, once raised, holds its payload
// stable until that edge.
module wb_master_seq
  import wbm_pkg::*;
#(
  parameter int ADDR_W         = WBM_ADDR_W,
  parameter int DATA_W         = WBM_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERRCNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we,
  output logic [DATA_W/8-1:0] wb_sel,
  output logic                wb_stb,
  input  logic                wb_ack,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count,
  output wbm_state_e          dbg_state
);

  // The strobe timer counts completed strobe cycles; the timeout fires on the
  // edge that ends strobe cycle TIMEOUT_CYCLES, i.e. when count == TIMEOUT-1.
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LIMIT =
    (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  wbm_state_e state;

  logic accept;
  logic to_load;
  logic to_clr;
  logic to_en;
  logic to_tc;
  logic timed_out;

  assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign to_en     = TO_EN && (state == ST_STROBE);
  assign timed_out = TO_EN && (state == ST_STROBE) && to_tc;

`ifdef WBM_RETRY_EN
  logic retry_gap;
  logic retry_tc;

  // A re-strobe out of GAP starts a fresh timeout window.
  assign to_load = accept || ((state == ST_GAP) && retry_gap);

  // Attempt counter: reaches its terminal value once the single retry is spent.
  wbm_timeout_timer #(
    .W (1)
  ) u_retry_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (accept),
    .load_val (1'b0),
    .en       (timed_out && !retry_tc),
    .limit    (1'b1),
    .tc       (retry_tc)
  );
`else
  assign to_load = accept;
`endif

  // Keep the strobe timer parked at zero whenever no strobe is running.
  assign to_clr = (state != ST_STROBE) && !to_load;

  wbm_timeout_timer #(
    .W (TO_W)
  ) u_to_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (to_clr),
    .load     (to_load),
    .load_val ('0),
    .en       (to_en),
    .limit    (TO_LIMIT),
    .tc       (to_tc)
  );

  // Main sequencer: all handshake and bus outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wb_addr   <= '0;
      wb_dat_o  <= '0;
      wb_we     <= 1'b0;
      wb_sel    <= '0;
      wb_stb    <= 1'b0;
      err_count <= '0;
`ifdef WBM_RETRY_EN
      retry_gap <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            wb_stb    <= 1'b1;
            wb_addr   <= cmd_addr;
            wb_we     <= cmd_we;
            wb_sel    <= cmd_sel;
            wb_dat_o  <= cmd_we ? cmd_wdata : '0;
            state     <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          // Ack is checked first so an ack on the terminal cycle wins.
          if (wb_ack) begin
            wb_stb    <= 1'b0;
            rsp_rdata <= wb_we ? '0 : wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timed_out) begin
            wb_stb <= 1'b0;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
`ifdef WBM_RETRY_EN
            if (!retry_tc) begin
              retry_gap <= 1'b1;
              state     <= ST_GAP;
            end else begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
`else
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
`endif
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
`ifdef WBM_RETRY_EN
          if (retry_gap) begin
            retry_gap <= 1'b0;
            wb_stb    <= 1'b1;
            state     <= ST_STROBE;
          end else begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
`else
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
`endif
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq with a small register-file slave whose
// ack can be disabled or delayed to a chosen strobe cycle.
module tb_wb_master_seq;
  import wbm_pkg::*;

  localparam int TO_CYC = 16;
`ifdef WBM_RETRY_EN
  localparam int EXP_PULSES = 2;
`else
  localparam int EXP_PULSES = 1;
`endif
  localparam int EXP_TO_ERRS = EXP_PULSES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  wb_addr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_ack;
  logic        busy;
  logic [7:0]  err_count;
  wbm_state_e  dbg_state;

  wb_master_seq #(
    .ADDR_W         (8),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO_CYC),
    .ERRCNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr   (wb_addr),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we     (wb_we),
    .wb_sel    (wb_sel),
    .wb_stb    (wb_stb),
    .wb_ack    (wb_ack),
    .busy      (busy),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // ---------------- slave model ----------------
  // Register 0 plays the watchdog-enable register of the protection block.
  logic [31:0] regs [4];
  logic [7:0]  stb_age;
  logic        ack_en;
  logic [7:0]  ack_at;

  assign wb_ack   = wb_stb && ack_en && (stb_age == ack_at);
  assign wb_dat_i = regs[wb_addr[3:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      stb_age <= 8'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
    end else begin
      stb_age <= wb_stb ? stb_age + 8'd1 : 8'd0;
      if (wb_stb && wb_ack && wb_we) regs[wb_addr[3:2]] <= wb_dat_o;
    end
  end

  // ---------------- bus monitor ----------------
  int cyc = 0;
  int cur_len = 0;
  int low_len = 0;
  int rsp_rises = 0;
  int rd_dat_viol = 0;
  logic prev_stb = 1'b0;
  logic prev_rsp = 1'b0;
  logic last_we;
  logic [3:0] last_sel;
  int pulse_q[$];
  int low_q[$];
  int rise_q[$];

  always @(negedge clk) begin
    cyc++;
    if (wb_stb === 1'b1) begin
      if (!prev_stb) begin
        rise_q.push_back(cyc);
        low_q.push_back(low_len);
      end
      cur_len++;
      low_len = 0;
      if (!wb_we && wb_dat_o != 32'd0) rd_dat_viol++;
      last_we  = wb_we;
      last_sel = wb_sel;
    end else begin
      if (prev_stb) pulse_q.push_back(cur_len);
      cur_len = 0;
      low_len++;
    end
    if (rsp_valid === 1'b1 && !prev_rsp) rsp_rises++;
    prev_stb = (wb_stb === 1'b1);
    prev_rsp = (rsp_valid === 1'b1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    pulse_q.delete();
    low_q.delete();
    rise_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input wbm_cmd_t c);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = c.we;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_sel   = c.sel;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    logic [32:0] exp;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    if (rsp_valid !== 1'b1) begin
      check({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
    end else begin
      check(tag, 64'({rsp_err, rsp_rdata}), 64'(exp));
    end
    @(negedge clk);
  endtask

  function automatic wbm_cmd_t mk(input logic we, input logic [7:0] a, input logic [31:0] d);
    wbm_cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.sel = 4'hF;
    return c;
  endfunction

  // ---------------- directed test ----------------
  initial begin
    int r0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'd0;
    cmd_wdata = 32'd0; cmd_sel = 4'd0; rsp_ready = 1'b1; ack_en = 1'b1; ack_at = 8'd0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_outputs", 64'({rsp_valid, rsp_err, wb_stb, wb_we, busy}), 64'd0);
    check("rst_data", 64'({rsp_rdata, wb_addr, wb_sel}), 64'd0);
    check("rst_dat_o", 64'(wb_dat_o), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // write watchdog enable, then read it back
    clear_mon();
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(mk(1'b1, 8'h00, 32'h0000_0001));
    wait_rsp("wr_wdog");
    check("wr_pulses", 64'(pulse_q.size()), 64'd1);
    if (pulse_q.size() > 0) check("wr_pulse_len", 64'(pulse_q[0]), 64'd1);
    check("wr_we_sel", 64'({last_we, last_sel}), 64'h1F);
    check("wdog_reg", 64'(regs[0]), 64'd1);
    exp_q.push_back({1'b0, 32'h0000_0001});
    send_cmd(mk(1'b0, 8'h00, 32'hFFFF_FFFF));
    wait_rsp("rd_wdog");

    // write/read register 1; wdata on the read command must not reach the bus
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(mk(1'b1, 8'h04, 32'h0000_1000));
    wait_rsp("wr_r1");
    rd_dat_viol = 0;
    exp_q.push_back({1'b0, 32'h0000_1000});
    send_cmd(mk(1'b0, 8'h04, 32'hDEAD_BEEF));
    wait_rsp("rd_r1");
    check("rd_dat_o_zero", 64'(rd_dat_viol), 64'd0);
    check("rd_we", 64'(last_we), 64'd0);

    // issue interval with responses drained immediately
    clear_mon();
    send_cmd(mk(1'b1, 8'h08, 32'h0000_00A5));
    send_cmd(mk(1'b1, 8'h08, 32'h0000_005A));
    repeat (8) @(negedge clk);
    check("b2b_rises", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() == 2) check("b2b_interval", 64'(rise_q[1] - rise_q[0]), 64'd4);
    check("b2b_reg", 64'(regs[2]), 64'h5A);

    // timeout: slave never acks
    clear_mon();
    ack_en = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(mk(1'b0, 8'h08, 32'h0));
    wait_rsp("timeout_rsp");
    check("to_pulses", 64'(pulse_q.size()), 64'(EXP_PULSES));
    foreach (pulse_q[i]) check("to_pulse_len", 64'(pulse_q[i]), 64'(TO_CYC));
    check("to_err_count", 64'(err_count), 64'(EXP_TO_ERRS));
`ifdef WBM_RETRY_EN
    if (low_q.size() == 2) check("retry_gap_len", 64'(low_q[1]), 64'd1);
`endif

    // ack on the terminal strobe cycle: no error
    clear_mon();
    ack_en = 1'b1;
    ack_at = 8'(TO_CYC - 1);
    exp_q.push_back({1'b0, 32'h0000_005A});
    send_cmd(mk(1'b0, 8'h08, 32'h0));
    wait_rsp("term_ack");
    check("term_pulses", 64'(pulse_q.size()), 64'd1);
    if (pulse_q.size() > 0) check("term_pulse_len", 64'(pulse_q[0]), 64'(TO_CYC));
    check("term_err_count", 64'(err_count), 64'(EXP_TO_ERRS));
    ack_at = 8'd0;

    // response backpressure: data held, no new command taken
    rsp_ready = 1'b0;
    send_cmd(mk(1'b0, 8'h04, 32'h0));
    begin
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    clear_mon();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h0C; cmd_wdata = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", 64'({rsp_valid, cmd_ready, wb_stb, rsp_err, rsp_rdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000}));
      @(negedge clk);
    end
    check("bp_no_strobe", 64'(rise_q.size()), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_gap", 64'({rsp_valid, cmd_ready}), 64'd0);
    check("bp_gap_state", 64'(dbg_state), 64'(ST_GAP));
    @(negedge clk);
    check("bp_ready_again", 64'(cmd_ready), 64'd1);
    check("bp_reg3_untouched", 64'(regs[3]), 64'd0);

    // reset during a strobe
    ack_en = 1'b0;
    send_cmd(mk(1'b0, 8'h0C, 32'h0));
    repeat (3) @(negedge clk);
    check("mid_stb_high", 64'(wb_stb), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_stb", 64'(wb_stb), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    r0 = rsp_rises;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_rsp", 64'(rsp_rises), 64'(r0));
    ack_en = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(mk(1'b1, 8'h0C, 32'h0000_CAFE));
    wait_rsp("post_rst_wr");
    exp_q.push_back({1'b0, 32'h0000_CAFE});
    send_cmd(mk(1'b0, 8'h0C, 32'h0));
    wait_rsp("post_rst_rd");
    check("post_rst_err_count", 64'(err_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
